// File: rtl/restoring_div4_pkg.sv
// Shared constants and FSM encoding for the 4-bit restoring divider.
package restoring_div4_pkg;

    localparam int unsigned Width = 4;
    localparam logic [Width-1:0] DivZeroQuot = 4'hF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/restoring_div4_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface restoring_div4_if;
    import restoring_div4_pkg::*;

    logic             start;
    logic [Width-1:0] dividend;
    logic [Width-1:0] divisor;
    logic             busy;
    logic             done;
    logic [Width-1:0] quotient;
    logic [Width-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/restoring_div4_cla_sub4.sv
// 4-bit carry-lookahead subtractor: a + ~b + 1, exposing the carry-out as the no-borrow flag.
module cla_sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] diff,
    output logic       c4
);

    logic [3:0] bn;
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign bn = ~b;
    assign p  = a ^ bn;
    assign g  = a & bn;

    assign c[0] = 1'b1;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign diff = p ^ c[3:0];
    assign c4   = c[4];

endmodule

// File: rtl/restoring_div4.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per cycle over four RUN cycles.
module restoring_div4
    import restoring_div4_pkg::*;
#(
    parameter int unsigned N = Width
) (
    input logic              clk,
    input logic              rst,
    restoring_div4_if.slave  div_bus
);

    state_e state_q, state_d;

    logic [N:0]   r_q, r_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] dvs_q, dvs_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [N-1:0] quot_q, quot_d;
    logic [N-1:0] rem_q, rem_d;
    logic         dbz_q, dbz_d;

    logic [N:0]   r_sh;
    logic [N-1:0] q_sh;
    logic [N-1:0] diff;
    logic         c4;
    logic         ge;
    logic [N:0]   r_nx;
    logic [N-1:0] q_nx;
    logic         accept;
    logic         last_iter;

    // One step of {R,Q} << 1 followed by a trial subtraction of the divisor.
    assign r_sh = {r_q[N-1:0], q_q[N-1]};
    assign q_sh = {q_q[N-2:0], 1'b0};

    cla_sub4 u_sub (
        .a    (r_sh[N-1:0]),
        .b    (dvs_q),
        .diff (diff),
        .c4   (c4)
    );

    assign ge        = r_sh[N] | c4;
    assign r_nx      = ge ? {1'b0, diff} : r_sh;
    assign q_nx      = {q_sh[N-1:1], ge};
    assign accept    = (state_q == StIdle) && div_bus.start;
    assign last_iter = (state_q == StRun) && (cnt_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (div_bus.start) begin
                    state_d = (div_bus.divisor == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (cnt_q == 2'd3) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        div_bus.busy = (state_q == StRun);
        div_bus.done = (state_q == StDone);
    end

    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        if (accept) begin
            r_d   = '0;
            q_d   = div_bus.dividend;
            dvs_d = div_bus.divisor;
            cnt_d = 2'd0;
            if (div_bus.divisor == '0) begin
                quot_d = DivZeroQuot;
                rem_d  = div_bus.dividend;
                dbz_d  = 1'b1;
            end
        end else if (state_q == StRun) begin
            r_d   = r_nx;
            q_d   = q_nx;
            cnt_d = cnt_q + 2'd1;
            if (last_iter) begin
                quot_d = q_nx;
                rem_d  = r_nx[N-1:0];
                dbz_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            q_q    <= '0;
            dvs_q  <= '0;
            cnt_q  <= 2'd0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

    assign div_bus.quotient    = quot_q;
    assign div_bus.remainder   = rem_q;
    assign div_bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_div4.sv
// Scoreboard bench for restoring_div4: driver queues expected results, monitor checks each done.
module tb_restoring_div4;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
        int         acc;
        int         done_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    restoring_div4_if bus ();

    restoring_div4 dut (
        .clk     (clk),
        .rst     (rst),
        .div_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input int acc);
        exp_t e;
        e.dbz      = (b == 4'd0);
        e.q        = e.dbz ? 4'hF : 4'(a / b);
        e.r        = e.dbz ? a : 4'(a % b);
        e.acc      = acc;
        e.done_cyc = acc + (e.dbz ? 0 : 4);
        return e;
    endfunction

    // Monitor: busy must match the head operation's RUN window; each done pops one result.
    always @(negedge clk) begin : mon
        exp_t h;
        bit   have;
        bit   exp_busy;
        if (!rst) begin
            have = (sb.size() > 0);
            if (have) h = sb[0];
            exp_busy = have && !h.dbz && (cyc >= h.acc) && (cyc <= h.acc + 3);
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            if (bus.done) begin
                if (!have) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected cyc=%0d got done=1 want done=0", cyc);
                end else begin
                    chk("done_cycle", cyc, h.done_cyc);
                    chk("quotient", 32'(bus.quotient), 32'(h.q));
                    chk("remainder", 32'(bus.remainder), 32'(h.r));
                    chk("div_by_zero", 32'(bus.div_by_zero), 32'(h.dbz));
                    void'(sb.pop_front());
                end
            end else if (have && cyc >= h.done_cyc) begin
                chk("done_pulse", 32'(bus.done), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout cyc=%0d got no done want done within 12 cycles", cyc);
        end
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+#1 with the DUT idle; noise pulses start with other operands mid-RUN.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input bit noise);
        sb.push_back(model(a, b, cyc + 1));
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 4'($urandom);
        bus.divisor  = 4'($urandom);
        if (noise && b != 4'd0) begin
            @(posedge clk);
            #1;
            bus.start    = 1'b1;
            bus.dividend = 4'd1;
            bus.divisor  = 4'd1;
            @(posedge clk);
            #1;
            bus.start    = 1'b0;
            bus.dividend = 4'($urandom);
            bus.divisor  = 4'($urandom);
        end
        wait_done();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_quotient"}, 32'(bus.quotient), 32'd0);
        chk({tag, "_remainder"}, 32'(bus.remainder), 32'd0);
        chk({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int c;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = 4'd0;
        bus.divisor  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");

        // Start presented straight after reset release must be accepted.
        rst = 1'b0;
        do_op(4'd13, 4'd3, 1'b0);
        do_op(4'd7, 4'd0, 1'b0);
        do_op(4'd2, 4'd5, 1'b0);
        do_op(4'd15, 4'd1, 1'b0);
        do_op(4'd15, 4'd15, 1'b0);
        do_op(4'd9, 4'd2, 1'b1);

        // Reset in the middle of RUN aborts with no done pulse.
        sb.push_back(model(4'd14, 4'd3, cyc + 1));
        bus.start    = 1'b1;
        bus.dividend = 4'd14;
        bus.divisor  = 4'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        chk_zero_outputs("abort");
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        do_op(4'd14, 4'd3, 1'b0);

        // Start held high: three operations six cycles apart.
        c = cyc;
        for (int i = 0; i < 3; i++) sb.push_back(model(4'd11, 4'd2, c + 1 + 6 * i));
        bus.start    = 1'b1;
        bus.dividend = 4'd11;
        bus.divisor  = 4'd2;
        repeat (13) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done();

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(4'(a), 4'(b), 1'b0);
            end
        end

        for (int i = 0; i < 40; i++) begin
            do_op(4'($urandom), 4'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/restoring_div4.md
RESTORING_DIV4 -- requirements
Module: restoring_div4

Interface
REQ-001 Parameter: N  4  operand width; only N=4 is supported, because the datapath uses the 4-bit carry-lookahead subtractor.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  in  1  request a division; sampled only in IDLE.
REQ-005 dividend  in  4  unsigned dividend; captured on the accepted start edge.
REQ-006 divisor  in  4  unsigned divisor; captured on the accepted start edge.
REQ-007 busy  out  1  high while the operation is in RUN.
REQ-008 done  out  1  one-cycle pulse; results are valid from this cycle on.
REQ-009 quotient  out  4  unsigned quotient.
REQ-010 remainder  out  4  unsigned remainder.
REQ-011 div_by_zero  out  1  high with done when the captured divisor was 0.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE, and IDLE SHALL be the reset state.
REQ-013 IDLE with start=1 SHALL capture the operands, set R(5b)=0, Q=dividend and iteration counter=0; a nonzero divisor SHALL go to RUN, and divisor=0 SHALL go directly to DONE.
REQ-014 In RUN, each cycle SHALL perform one iteration: shift {R,Q} left by 1; diff = R[3:0] + ~divisor + 1 computed by the CLA, with C4 as carry-out.
REQ-015 Each iteration SHALL compute ge = R[4] | C4; if ge=1 then R={0,diff} and Q[0]=1, otherwise R is unchanged and Q[0]=0.
REQ-016 RUN SHALL last exactly 4 cycles; after the 4th iteration (counter=3) the FSM SHALL go to DONE.
REQ-017 Latency: with start accepted at edge k, done SHALL be high in the cycle following edge k+5, and busy SHALL be high for the cycles following edges k+1..k+4.
REQ-018 DONE SHALL last one cycle and SHALL return to IDLE unconditionally; done=1 only in DONE.
REQ-019 quotient/remainder SHALL be loaded on entry to DONE and held until the next accepted start or reset.
REQ-020 On divide-by-zero, DONE SHALL be reached at edge k+1 with quotient=4'hF, remainder=dividend and div_by_zero=1; otherwise div_by_zero=0.
REQ-021 start in RUN or DONE SHALL be ignored, with no queuing; start must be reasserted in IDLE.
REQ-022 Operand changes after the accepted start SHALL NOT affect the result.
REQ-023 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, for all 240 nonzero-divisor pairs.
REQ-024 Back-to-back operation: start held high SHALL begin a new operation in the IDLE cycle following DONE, giving a 6-cycle repeat interval.

Reset
REQ-025 rst=1 SHALL force IDLE with busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear R, Q and the counter.
REQ-026 rst in any state, including mid-RUN, SHALL abort the operation with no done pulse; rst has priority over start.
REQ-027 start sampled on the first edge after rst deasserts SHALL be accepted normally.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE/RUN/DONE), the N=4 width constant and the divide-by-zero quotient constant 4'hF.
REQ-029 The subtraction SHALL be a single sub-module, cla_sub4: a 4-bit carry-lookahead adder with B inverted and C0=1, outputs diff[3:0] and C4. It is purely combinational and reuses the team's propagate/generate cell structure.
REQ-030 The control FSM, 2-bit counter and R/Q registers SHALL reside in restoring_div4; no other hierarchy is required.

Verification
REQ-031 13/3: start at k -> busy for 4 cycles, done at k+5 with quotient=4, remainder=1, div_by_zero=0.
REQ-032 7/0 -> done at k+1 with quotient=F, remainder=7, div_by_zero=1, and busy never high.
REQ-033 2/5 -> quotient=0, remainder=2; 15/1 -> quotient=15, remainder=0; 15/15 -> quotient=1, remainder=0.
REQ-034 Start 9/2, pulse start with 1/1 in RUN and change the operands -> result 4 r 1 and exactly one done pulse.
REQ-035 Start 14/3, assert rst at k+2 -> all outputs 0, no done pulse; a following 14/3 -> 4 r 2.
REQ-036 Exhaustive: all 256 pairs checked against REQ-020/REQ-023, including done timing.
